delta_issue_scheduler: RTL
==========================

Name: delta_issue_scheduler

Overview:
- Shares the output filter's single delta input (dv/chan/delta) among N_CHAN independent PID delta producers.
- Holds one pending delta per channel and merges late arrivals into it by saturating addition.
- Grants channels round-robin.
- Enforces a minimum same-channel re-issue spacing, so the filter's per-channel previous-output read-modify-write never sees a hazard.
- Inserts idle bubbles on request so the filter can perform initial-value injections.

Parameters:
- W_CHAN, 5, channel index width
- N_CHAN, 8, number of requesting channels (≤ 2^W_CHAN)
- W_DELTA, 128, signed delta width
- HAZ_GAP, 5, minimum cycles between two issues of the same channel (≥1)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; asynchronous, active-low
- req_dv_in  in  N_CHAN  per-channel delta valid pulse
- req_delta_in  in  N_CHAN*W_DELTA  packed signed deltas; channel i at [i*W_DELTA +: W_DELTA]
- bubble_rqst_in  in  1  level; requests idle cycles on the output
- ovf_clr_in  in  N_CHAN  per-channel clear of sticky overflow flags
- dv_out  out  1  delta valid to output filter
- chan_out  out  W_CHAN  channel of issued delta
- delta_out  out  W_DELTA  signed issued delta
- pend_out  out  N_CHAN  pending flags, one per channel
- ovf_out  out  N_CHAN  sticky merge-saturation flags

Behaviour:
- Reset (rst_in=0, async):
  - dv_out=0, chan_out=0, delta_out=0.
  - pend/ovf/hold counters cleared.
  - RR pointer = N_CHAN-1, so channel 0 is highest priority after reset.
  - Reset mid-issue drops all pending data.
- Capture, per channel i on a clock edge with req_dv_in[i]=1:
  - Not pending, or pending but issued this same edge: pending value <= req delta; pend[i] <= 1.
  - Pending and not issued this edge: pending <= sat(pending + req delta) at W_DELTA signed. If clamped to +max or -min, set ovf[i].
- Eligibility: pend[i]=1 and hold[i]=0.
- Arbitration, one grant per cycle:
  - Grant the first eligible channel scanning ptr+1, ptr+2, ... modulo N_CHAN.
  - On grant: ptr <= granted index; hold[granted] <= HAZ_GAP-1; pend cleared unless a new capture occurs on the same edge.
- Hold counters: nonzero values decrement by 1 every cycle; they saturate at 0.
- Output is registered. A grant decided in cycle t gives dv_out=1 with chan/delta in cycle t+1.
- Latency: req_dv_in[i] sampled at edge k → dv_out high after edge k+1 at the earliest.
- No eligible channel: dv_out <= 0; chan_out/delta_out hold their previous values.
- Bubble: if bubble_rqst_in=1 and dv_out=1 in the current cycle, no grant is made and dv_out <= 0 at the next edge. While bubble_rqst_in is held, the output therefore never has two consecutive valid cycles.
- Same-channel spacing: two dv_out pulses for channel i are ≥ HAZ_GAP cycles apart. HAZ_GAP=1 allows back-to-back issue.
- ovf_clr_in[i] clears ovf[i]. A simultaneous set wins over the clear.
- pend_out and ovf_out are direct register outputs.
- Channel indices ≥ N_CHAN are never issued.

Test Plan:
- Reset release, channel 0 pulses delta=+7 at edge 10 → dv_out=1, chan_out=0, delta_out=7 after edge 11. pend_out[0] falls at the same edge.
- Channels 0,1,2 pulse in the same cycle with 10, 20, 30 → issued in order 0,1,2 on consecutive cycles. Repeating with channels 1,2,0 pending and ptr=0 → order 1,2,0.
- Channel 3 pulses 5 then 6 before it can issue (blocked by HAZ_GAP) → a single issue with delta 11, no overflow.
- Channel 4 pending at 2^(W_DELTA-1)-10, then +100 arrives → delta_out = 2^(W_DELTA-1)-1 and ovf_out[4]=1. ovf_clr_in[4] pulse → 0.
- Channel 5 requests every cycle, HAZ_GAP=5 → dv_out for chan 5 exactly every 5 cycles. Other channels fill the gaps.
- bubble_rqst_in held high with all channels pending → dv_out alternates 1,0,1,0.
- Reset asserted while 3 channels are pending → outputs 0 immediately; nothing issued after release.

Source files
------------

// File: rtl/delta_issue_scheduler.sv
// Round-robin issue scheduler: shares one delta port among N_CHAN producers, merging late
// deltas with saturation and spacing same-channel issues by at least HAZ_GAP cycles.
module delta_issue_scheduler #(
  parameter int unsigned W_CHAN  = 5,
  parameter int unsigned N_CHAN  = 8,
  parameter int unsigned W_DELTA = 128,
  parameter int unsigned HAZ_GAP = 5
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [N_CHAN-1:0]           req_dv_in,
  input  logic [N_CHAN*W_DELTA-1:0]   req_delta_in,
  input  logic                        bubble_rqst_in,
  input  logic [N_CHAN-1:0]           ovf_clr_in,
  output logic                        dv_out,
  output logic [W_CHAN-1:0]           chan_out,
  output logic [W_DELTA-1:0]          delta_out,
  output logic [N_CHAN-1:0]           pend_out,
  output logic [N_CHAN-1:0]           ovf_out
);

  localparam int unsigned W_HOLD = (HAZ_GAP > 1) ? $clog2(HAZ_GAP) : 1;
  localparam logic [W_HOLD-1:0]  HOLD_INIT = W_HOLD'(HAZ_GAP - 1);
  localparam logic [W_DELTA-1:0] DMAX = {1'b0, {(W_DELTA-1){1'b1}}};
  localparam logic [W_DELTA-1:0] DMIN = {1'b1, {(W_DELTA-1){1'b0}}};

  logic [N_CHAN-1:0]  pend_q, pend_d, ovf_q, ovf_d;
  logic [W_DELTA-1:0] val_q [N_CHAN];
  logic [W_DELTA-1:0] val_d [N_CHAN];
  logic [W_HOLD-1:0]  hold_q [N_CHAN];
  logic [W_HOLD-1:0]  hold_d [N_CHAN];
  logic [W_CHAN-1:0]  ptr_q, ptr_d;
  logic               dv_q, dv_d;
  logic [W_CHAN-1:0]  chan_q, chan_d;
  logic [W_DELTA-1:0] delta_q, delta_d;

  logic [W_DELTA-1:0] req_d [N_CHAN];
  logic [W_DELTA:0]   sum [N_CHAN];
  logic [N_CHAN-1:0]  sat, gnt_hit;
  logic [2**W_CHAN-1:0] elig_ext;
  logic [W_CHAN-1:0]  scan, gnt_idx;
  logic               gnt_vld;

  // Sign-extended sum; the two top bits disagree exactly when the W_DELTA result overflows.
  always_comb begin
    for (int i = 0; i < N_CHAN; i++) begin
      req_d[i] = req_delta_in[i*W_DELTA +: W_DELTA];
      sum[i]   = {val_q[i][W_DELTA-1], val_q[i]} + {req_d[i][W_DELTA-1], req_d[i]};
      sat[i]   = sum[i][W_DELTA] ^ sum[i][W_DELTA-1];
    end
  end

  // Padding to 2**W_CHAN keeps out-of-range indices permanently ineligible.
  always_comb begin
    elig_ext = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      elig_ext[i] = pend_q[i] && (hold_q[i] == '0);
    end
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int unsigned k = 1; k <= N_CHAN; k++) begin
      scan = W_CHAN'((32'(ptr_q) + k) % N_CHAN);
      if (!gnt_vld && elig_ext[scan]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan;
      end
    end
    if (bubble_rqst_in && dv_q) begin
      gnt_vld = 1'b0;
    end
    for (int i = 0; i < N_CHAN; i++) begin
      gnt_hit[i] = gnt_vld && (gnt_idx == W_CHAN'(i));
    end
  end

  always_comb begin
    pend_d  = pend_q;
    ovf_d   = ovf_q & ~ovf_clr_in;
    val_d   = val_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    dv_d    = gnt_vld;
    chan_d  = chan_q;
    delta_d = delta_q;
    if (gnt_vld) begin
      ptr_d  = gnt_idx;
      chan_d = gnt_idx;
    end
    for (int i = 0; i < N_CHAN; i++) begin
      if (hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - 1'b1;
      end
      if (gnt_hit[i]) begin
        hold_d[i] = HOLD_INIT;
        pend_d[i] = 1'b0;
        delta_d   = val_q[i];
      end
      // A capture on the grant edge starts a fresh value; otherwise it merges.
      if (req_dv_in[i]) begin
        pend_d[i] = 1'b1;
        if (!pend_q[i] || gnt_hit[i]) begin
          val_d[i] = req_d[i];
        end else if (sat[i]) begin
          val_d[i] = sum[i][W_DELTA] ? DMIN : DMAX;
          ovf_d[i] = 1'b1;
        end else begin
          val_d[i] = sum[i][W_DELTA-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_q  <= '0;
      ovf_q   <= '0;
      ptr_q   <= W_CHAN'(N_CHAN - 1);
      dv_q    <= 1'b0;
      chan_q  <= '0;
      delta_q <= '0;
      for (int i = 0; i < N_CHAN; i++) begin
        val_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      dv_q    <= dv_d;
      chan_q  <= chan_d;
      delta_q <= delta_d;
      for (int i = 0; i < N_CHAN; i++) begin
        val_q[i]  <= val_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign dv_out    = dv_q;
  assign chan_out  = chan_q;
  assign delta_out = delta_q;
  assign pend_out  = pend_q;
  assign ovf_out   = ovf_q;

endmodule
